// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU result stage: op encodings, flag bit
// positions and the flag-vector width.
// Optional feature macro: ALU_PARITY_FLAG_EN adds the even-parity flag P.
package alu_stage_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } alu_op_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_P = 3;

`ifdef ALU_PARITY_FLAG_EN
    localparam int unsigned FLAG_W = 4;
`else
    localparam int unsigned FLAG_W = 3;
`endif

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding {flags, value} entries for the result stage.
// DEPTH must be a power of two so the pointers wrap naturally.
// The head reads as zero while empty so the outputs are clean after reset.
module result_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CntW'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, the head is gated by empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Head of queue, shown directly with no output register.
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after the 8-bit operand/result mux: accumulator,
// PASS/ADD/SUB/CLEAR arithmetic, flag generation, and an output FIFO.
// Optional feature macro: ALU_PARITY_FLAG_EN adds the even-parity flag P.
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [WIDTH-1:0]  acc
);

    localparam int unsigned EntryW = WIDTH + FLAG_W;

    alu_op_e           op;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  result;
    logic [WIDTH:0]    wide;
    logic              carry;
    logic [FLAG_W-1:0] flags;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EntryW-1:0] push_entry;
    logic [EntryW-1:0] head_entry;

    assign op = alu_op_e'(in_op);

    // in_ready depends only on FIFO occupancy, never on out_ready.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign accept    = in_valid && in_ready;
    assign acc       = acc_q;

    // Candidate accumulator value and carry/borrow for the presented op.
    always_comb begin
        wide   = '0;
        result = acc_q;
        carry  = 1'b0;
        unique case (op)
            OP_PASS: begin
                result = in_data;
            end
            OP_ADD: begin
                wide   = {1'b0, acc_q} + {1'b0, in_data};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is set exactly on borrow.
                wide   = {1'b0, acc_q} - {1'b0, in_data};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            OP_CLEAR: begin
                result = '0;
            end
            default: begin
                result = acc_q;
            end
        endcase
    end

    // Status flags computed on the new value.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_C] = carry;
`ifdef ALU_PARITY_FLAG_EN
        flags[FLAG_P] = ~^result;
`endif
    end

    // Accumulator updates on the same edge the entry is pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= result;
        end
    end

    assign push_entry = {flags, result};

    result_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (push_entry),
        .pop   (out_ready),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data  = head_entry[WIDTH-1:0];
    assign out_flags = head_entry[EntryW-1:WIDTH];

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Honours ALU_PARITY_FLAG_EN through the package FLAG_W.
`timescale 1ns/1ps
module tb_alu_result_stage;
    import alu_stage_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data   = '0;
    logic [1:0]        in_op     = 2'b00;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic [FLAG_W-1:0] out_flags;
    logic [WIDTH-1:0]  acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .acc       (acc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FLAG_W-1:0] mk_flags(input logic p, input logic c,
                                                    input logic n, input logic z);
        logic [3:0] f;
        f = {p, c, n, z};
        return f[FLAG_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted (bounded wait).
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) check_eq("send_ready_timeout", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] data,
                              input logic [FLAG_W-1:0] flags);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'b0, out_data}, {24'b0, data});
        check_eq({tag, "_flags"}, {28'b0, 4'(out_flags)}, {28'b0, 4'(flags)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a valid request pending: nothing may be pushed.
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_data  = 8'h33;
        tick();
        tick();
        tick();
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_acc", {24'b0, acc}, 32'd0);
        check_eq("rst_out_data", {24'b0, out_data}, 32'd0);
        check_eq("rst_out_flags", {28'b0, 4'(out_flags)}, 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check_eq("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

        // PASS then ADD across the sign boundary.
        out_ready = 1'b1;
        send(OP_PASS, 8'h7F);
        check_head("pass7f", 8'h7F, mk_flags(1'b0, 1'b0, 1'b0, 1'b0));
        send(OP_ADD, 8'h01);
        check_head("add01", 8'h80, mk_flags(1'b0, 1'b0, 1'b1, 1'b0));
        check_eq("add01_acc", {24'b0, acc}, 32'h80);
        tick();
        check_eq("drain1_out_valid", {31'b0, out_valid}, 32'd0);

        // Carry, borrow and clear.
        send(OP_PASS, 8'hF0);
        check_head("passf0", 8'hF0, mk_flags(1'b1, 1'b0, 1'b1, 1'b0));
        send(OP_ADD, 8'h20);
        check_head("add20", 8'h10, mk_flags(1'b0, 1'b1, 1'b0, 1'b0));
        send(OP_SUB, 8'h11);
        check_head("sub11", 8'hFF, mk_flags(1'b1, 1'b1, 1'b1, 1'b0));
        send(OP_CLEAR, 8'hA5);
        check_head("clear", 8'h00, mk_flags(1'b1, 1'b0, 1'b0, 1'b1));
        check_eq("clear_acc", {24'b0, acc}, 32'd0);
        tick();
        check_eq("drain2_out_valid", {31'b0, out_valid}, 32'd0);

        // Fill while stalled, then release with one bubble.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_PASS;
        in_data   = 8'h01;
        tick();
        check_eq("fill1_in_ready", {31'b0, in_ready}, 32'd1);
        in_data = 8'h02;
        tick();
        check_eq("fill2_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("fill2_out_data", {24'b0, out_data}, 32'h01);
        in_data = 8'h03;
        tick();
        check_eq("full_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("full_acc", {24'b0, acc}, 32'h02);
        check_eq("full_out_data", {24'b0, out_data}, 32'h01);
        out_ready = 1'b1;
        tick();
        check_eq("bubble_in_ready", {31'b0, in_ready}, 32'd1);
        check_head("bubble", 8'h02, mk_flags(1'b0, 1'b0, 1'b0, 1'b0));
        check_eq("bubble_acc", {24'b0, acc}, 32'h02);
        tick();
        check_head("after_bubble", 8'h03, mk_flags(1'b1, 1'b0, 1'b0, 1'b0));
        check_eq("after_bubble_acc", {24'b0, acc}, 32'h03);
        in_valid = 1'b0;
        tick();
        check_eq("drain3_out_valid", {31'b0, out_valid}, 32'd0);

        // Streaming: one result per cycle, FIFO never fills.
        send(OP_CLEAR, 8'h00);
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_data  = 8'h01;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_eq($sformatf("stream%0d_data", i), {24'b0, out_data}, 32'(i));
            check_eq($sformatf("stream%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check_eq("drain4_out_valid", {31'b0, out_valid}, 32'd0);

        // Reset while two entries are queued.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_PASS;
        in_data   = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        check_eq("prerst_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("prerst_out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("midrst_acc", {24'b0, acc}, 32'd0);
        check_eq("midrst_out_data", {24'b0, out_data}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(OP_PASS, 8'h55);
        check_head("pass55", 8'h55, mk_flags(1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check_eq("pass55_alone", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
